// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default fetch widths, reset PC and fetch FSM encoding.
package cpu_pkg;

  localparam int          DEFAULT_ADDR_W   = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W          = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, core delivery and redirect.
interface instr_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc, pc_out,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, pc_out,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and a flush that empties it in one cycle.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order memory requests,
// buffered delivery to the core and redirect with wrong-path response draining.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e                state;
  fetch_state_e                state_nxt;
  logic [ADDR_W-1:0]           pc;
  logic [ADDR_W-1:0]           pc_nxt;
  logic [CNT_W-1:0]            discard;
  logic [CNT_W-1:0]            discard_nxt;
  logic [CNT_W-1:0]            inflight_cnt;
  logic [CNT_W-1:0]            out_cnt;
  logic [CNT_W:0]              occupancy;
  logic                        inflight_empty;
  logic                        inflight_full;
  logic                        out_empty;
  logic                        out_full;
  logic                        fifo_flags_unused;
  logic                        req;
  logic                        grant;
  logic                        resp;
  logic                        redir_take;
  logic                        out_push;
  logic [ADDR_W-1:0]           resp_pc;
  logic [ADDR_W+INSTR_W-1:0]   out_head;

  // Slots are reserved at grant time, so the output FIFO can never overflow.
  assign occupancy  = {1'b0, inflight_cnt} + {1'b0, out_cnt};
  assign resp       = bus.imem_rvalid && !inflight_empty;
  assign redir_take = bus.redirect && (state != BOOT);
  assign req        = (state == RUN) && !bus.redirect && (occupancy < (CNT_W+1)'(DEPTH));
  assign grant      = req && bus.imem_gnt;
  assign out_push   = resp && (state == RUN) && !redir_take;

  assign fifo_flags_unused = inflight_full | out_full;

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_inflight_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant),
    .push_data (pc),
    .pop       (resp),
    .flush     (1'b0),
    .head      (resp_pc),
    .count     (inflight_cnt),
    .empty     (inflight_empty),
    .full      (inflight_full)
  );

  fetch_fifo #(.WIDTH(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (out_push),
    .push_data ({resp_pc, bus.imem_rdata}),
    .pop       (bus.instr_ready),
    .flush     (redir_take),
    .head      (out_head),
    .count     (out_cnt),
    .empty     (out_empty),
    .full      (out_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      discard <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    case (state)
      BOOT:  state_nxt = RUN;
      RUN: begin
        if (grant) begin
          pc_nxt = pc + ADDR_W'(4);
        end
      end
      DRAIN: begin
        if (resp) begin
          discard_nxt = discard - CNT_W'(1);
        end
        if (discard_nxt == '0) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
    // A response landing in the redirect cycle is already wrong-path, so it is not counted.
    if (redir_take) begin
      pc_nxt      = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      discard_nxt = inflight_cnt - (resp ? CNT_W'(1) : CNT_W'(0));
      state_nxt   = (discard_nxt != '0) ? DRAIN : RUN;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.pc_out      = pc;
  assign bus.instr_valid = !out_empty;
  assign {bus.instr_pc, bus.instr_out} = out_head;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench: memory/core environment plus an address-stream reference model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  logic clk;
  logic rst_n;

  instr_fetch_unit_if #(.ADDR_W(32)) bus ();
  instr_fetch_unit_if #(.ADDR_W(32)) bus_w ();

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          cycle     = 0;
  int          grants    = 0;
  int          accepts   = 0;
  int          wrap_grants = 0;
  int          gnt_pct, rdy_pct, redir_pct, lat_min, lat_max;
  bit          force_redir = 0;
  logic [31:0] force_target;
  logic [31:0] exp_pc, exp_req_pc, last_accept_pc;
  logic        prev_req, prev_gnt;
  logic [31:0] prev_addr;
  logic        w_pend;
  pend_t       pending[$];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic int live_count();
    int n = 0;
    foreach (pending[i]) if (!pending[i].stale) n++;
    return n;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else pass_cnt++;
  endtask

  // Sample at negedge+1 and advance the reference model as if the coming edge happens.
  task automatic observe();
    if (rst_n) begin
      if (prev_req && !prev_gnt && !bus.redirect) begin
        check_output("hold_req", 64'(bus.imem_req), 64'd1);
        check_output("hold_addr", 64'(bus.imem_addr), 64'(prev_addr));
      end
      if (live_count() >= DEPTH) check_output("cap_req", 64'(bus.imem_req), 64'd0);
      if (bus.redirect) check_output("redir_no_req", 64'(bus.imem_req), 64'd0);
      if (bus.imem_req && bus.imem_gnt) begin
        check_output("req_addr", 64'(bus.imem_addr), 64'(exp_req_pc));
        pending.push_back('{addr: bus.imem_addr, due: cycle + int'($urandom_range(lat_max, lat_min)), stale: 1'b0});
        exp_req_pc = exp_req_pc + 32'd4;
        grants++;
      end
      if (bus.instr_valid && bus.instr_ready) begin
        check_output("instr_pc", 64'(bus.instr_pc), 64'(exp_pc));
        check_output("instr_out", 64'(bus.instr_out), 64'(mem_word(exp_pc)));
        last_accept_pc = bus.instr_pc;
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      if (bus.redirect) begin
        exp_pc     = {bus.redirect_pc[31:2], 2'b00};
        exp_req_pc = {bus.redirect_pc[31:2], 2'b00};
      end
      prev_req  = bus.imem_req;
      prev_gnt  = bus.imem_gnt;
      prev_addr = bus.imem_addr;
      if (bus_w.imem_req && bus_w.imem_gnt) begin
        if (wrap_grants == 0) check_output("wrap_addr0", 64'(bus_w.imem_addr), 64'h0000_0000_FFFF_FFFC);
        if (wrap_grants == 1) check_output("wrap_addr1", 64'(bus_w.imem_addr), 64'h0);
        wrap_grants++;
        w_pend = 1'b1;
      end else begin
        w_pend = 1'b0;
      end
    end else begin
      prev_req = 1'b0;
      w_pend   = 1'b0;
    end
    if (bus.imem_rvalid) void'(pending.pop_front());
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    cycle++;
    bus.redirect    = force_redir || (int'($urandom_range(99)) < redir_pct);
    bus.redirect_pc = force_redir ? force_target : $urandom;
    force_redir     = 1'b0;
    bus.imem_gnt    = int'($urandom_range(99)) < gnt_pct;
    if (pending.size() > 0 && pending[0].due <= cycle) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pending[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    bus.instr_ready   = int'($urandom_range(99)) < rdy_pct;
    bus_w.imem_gnt    = 1'b1;
    bus_w.instr_ready = 1'b1;
    bus_w.redirect    = 1'b0;
    bus_w.imem_rvalid = w_pend;
    bus_w.imem_rdata  = $urandom;
    #1;
    observe();
  endtask

  task automatic set_mode(input int g, input int r, input int d, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; redir_pct = d; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_req"}, 64'(bus.imem_req), 64'd0);
    check_output({tag, "_valid"}, 64'(bus.instr_valid), 64'd0);
    check_output({tag, "_pc_out"}, 64'(bus.pc_out), 64'd0);
    check_output({tag, "_instr_out"}, 64'(bus.instr_out), 64'd0);
    check_output({tag, "_instr_pc"}, 64'(bus.instr_pc), 64'd0);
  endtask

  initial begin
    int g0, a0;
    rst_n = 1'b0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.instr_ready = 0;
    bus.redirect = 0; bus.redirect_pc = 0;
    bus_w.imem_gnt = 0; bus_w.imem_rvalid = 0; bus_w.imem_rdata = 0; bus_w.instr_ready = 0;
    bus_w.redirect = 0; bus_w.redirect_pc = 0;
    prev_req = 0; prev_gnt = 0; prev_addr = 0; w_pend = 0;
    exp_pc = 0; exp_req_pc = 0; last_accept_pc = 32'hDEAD_BEEF;
    set_mode(100, 0, 0, 1, 1);

    repeat (14) @(negedge clk);
    #1;
    check_reset_values("reset");
    check_output("wrap_pc_reset", 64'(bus_w.pc_out), 64'h0000_0000_FFFF_FFFC);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("boot_req", 64'(bus.imem_req), 64'd0);
    check_output("wrap_boot_req", 64'(bus_w.imem_req), 64'd0);

    // Backpressure from the first fetch: two grants fill the slots, head stays at PC 0.
    apply_stimulus();
    check_output("first_req", 64'({bus.imem_req, bus.imem_addr}), 64'({1'b1, 32'h0}));
    g0 = grants;
    repeat (9) apply_stimulus();
    check_output("bp_grants", 64'(grants - g0 + 1), 64'd2);
    check_output("bp_req", 64'(bus.imem_req), 64'd0);
    check_output("bp_valid", 64'(bus.instr_valid), 64'd1);
    check_output("bp_pc", 64'(bus.instr_pc), 64'd0);

    // Grant stall: address must sit at 0x8 until granted.
    set_mode(0, 100, 0, 1, 1);
    repeat (6) apply_stimulus();
    check_output("stall_req", 64'({bus.imem_req, bus.imem_addr}), 64'({1'b1, 32'h8}));
    set_mode(100, 100, 0, 1, 1);
    repeat (2) apply_stimulus();
    check_output("stall_next_addr", 64'(bus.imem_addr), 64'hC);
    check_output("stall_pc_out", 64'(bus.pc_out), 64'hC);

    repeat (20) apply_stimulus();

    // Redirect while two requests are outstanding.
    set_mode(0, 100, 0, 1, 1);
    for (int i = 0; i < 20 && pending.size() > 0; i++) apply_stimulus();
    repeat (3) apply_stimulus();
    set_mode(100, 100, 0, 4, 4);
    g0 = grants;
    repeat (2) apply_stimulus();
    check_output("redir_outstanding", 64'(grants - g0), 64'd2);
    set_mode(100, 100, 0, 1, 1);
    force_redir  = 1'b1;
    force_target = 32'h0000_0103;
    apply_stimulus();
    apply_stimulus();
    check_output("drain_no_req", 64'(bus.imem_req), 64'd0);
    check_output("flush_valid", 64'(bus.instr_valid), 64'd0);
    a0 = accepts;
    for (int i = 0; i < 20 && accepts == a0; i++) apply_stimulus();
    check_output("redir_first_pc", 64'(last_accept_pc), 64'h100);

    set_mode(70, 70, 3, 1, 5);
    repeat (1500) apply_stimulus();

    // Reset mid-operation; responses still in flight come back afterwards and must be ignored.
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    foreach (pending[i]) pending[i].stale = 1'b1;
    set_mode(0, 100, 0, 1, 5);
    repeat (2) apply_stimulus();
    rst_n = 1'b1;
    #1;
    check_output("mid_boot_req", 64'(bus.imem_req), 64'd0);
    exp_pc = 0; exp_req_pc = 0; prev_req = 0;
    for (int i = 0; i < 20 && pending.size() > 0; i++) apply_stimulus();
    check_output("stale_ignored", 64'(bus.instr_valid), 64'd0);
    check_output("stale_pc_out", 64'(bus.pc_out), 64'd0);

    set_mode(70, 70, 3, 1, 5);
    repeat (1500) apply_stimulus();

    check_output("progress", 64'(accepts > 300), 64'd1);
    check_output("wrap_seen", 64'(wrap_grants >= 2), 64'd1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
